// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
//   PC_START_ADDR : byte address of instruction word 0 (reset PC)
//   IMEM_NOP      : instruction returned on a faulting fetch (addi x0,x0,0)
//   imem_rsp_t    : one queued response {addr, inst, err}
package imem_responder_pkg;

  localparam logic [31:0] PC_START_ADDR = 32'h8000_0000;
  localparam logic [31:0] IMEM_NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO for the instruction-memory responder.
// Holds imem_rsp_t entries in arrival order; the head is presented
// combinationally on rd_data_o and reads as all-zero while empty.
// Ports:
//   clk, rst   clock / synchronous active-low reset
//   clr_i      drop every entry this edge (wins over a same-cycle write)
//   wr_en_i    push wr_data_i
//   rd_en_i    pop the head
//   rd_data_o  head entry (zero when empty)
//   full_o     DEPTH entries held
//   empty_o    no entries held
module imem_rsp_fifo
  import imem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr_i,
  input  logic      wr_en_i,
  input  imem_rsp_t wr_data_i,
  input  logic      rd_en_i,
  output imem_rsp_t rd_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  imem_rsp_t       mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q,  cnt_d;
  logic            do_wr, do_rd;

  // Explicit wrap keeps the pointers legal for any DEPTH, including 1.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_wr) wptr_d = bump(wptr_q);
    if (do_rd) rptr_d = bump(rptr_q);
    if (do_wr && !do_rd)      cnt_d = cnt_q + 1'b1;
    else if (do_rd && !do_wr) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; pointers/count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/imem_responder.sv
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS     = 1024,
  parameter int    LATENCY         = 2,
  parameter int    MAX_OUTSTANDING = 4,
  parameter string INIT_FILE       = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_addr,
  output logic [31:0] rsp_inst,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, pop;
  logic          fifo_full, fifo_empty;
  imem_rsp_t     fifo_wdata, fifo_rdata;

  assign req_ready = !flush && (cnt_q < CW'(MAX_OUTSTANDING));
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !accept) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end

  logic [31:0]   off;
  logic [AW-1:0] idx_d;
  logic          err_d;

  assign off   = req_addr - PC_START_ADDR;
  assign idx_d = off[AW+1:2];

`ifdef IMEM_ERR_CHECK_EN
  assign err_d = (off[1:0] != 2'b00) || (off[31:AW+2] != '0);
`else
  assign err_d = 1'b0;
  logic unused_off;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
`endif

  logic [LATENCY-1:0]         vld_pipe_q;
  logic [LATENCY-1:0][31:0]   addr_pipe_q;
  logic [LATENCY-1:0][AW-1:0] idx_pipe_q;
  logic [LATENCY-1:0]         err_pipe_q;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= accept;
      for (int k = 1; k < LATENCY; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_pipe_q[0] <= req_addr;
    idx_pipe_q[0]  <= idx_d;
    err_pipe_q[0]  <= err_d;
    for (int k = 1; k < LATENCY; k++) begin
      addr_pipe_q[k] <= addr_pipe_q[k-1];
      idx_pipe_q[k]  <= idx_pipe_q[k-1];
      err_pipe_q[k]  <= err_pipe_q[k-1];
    end
  end

  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.addr = addr_pipe_q[LATENCY-1];
    fifo_wdata.err  = err_pipe_q[LATENCY-1];
    fifo_wdata.inst = err_pipe_q[LATENCY-1] ? IMEM_NOP
                                            : mem_q[idx_pipe_q[LATENCY-1]];
  end

  imem_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (flush),
    .wr_en_i   (vld_pipe_q[LATENCY-1]),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  logic unused_full;
  assign unused_full = fifo_full;

  assign rsp_valid = !fifo_empty;
  assign rsp_addr  = fifo_rdata.addr;
  assign rsp_inst  = fifo_rdata.inst;
  assign rsp_err   = fifo_rdata.err;

endmodule
